// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HANDOFF = 2'd2
  } arb_state_t;

  // Binary owner index to one-hot grant vector.
  function automatic logic [ARB_N-1:0] idx_to_onehot(input logic [ARB_IDX_W-1:0] idx);
    logic [ARB_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter8_if;
  import arb_pkg::*;

  logic [ARB_N-1:0]     req;
  logic [ARB_N-1:0]     gnt;
  logic [ARB_IDX_W-1:0] gnt_idx;
  logic                 gnt_valid;

  // Requester side: raises req, watches the grant.
  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );

  // Arbiter side.
  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );

endinterface

// File: rtl/rr_arbiter8_pick8.sv
// Combinational round-robin winner search: first set request at or after ptr, wrapping 7->0.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_IDX_W-1:0] ptr,
  output logic                 found,
  output logic [ARB_IDX_W-1:0] idx
);

  logic [ARB_N-1:0]     rot_s;
  logic [ARB_IDX_W-1:0] src_s;
  logic [ARB_IDX_W-1:0] off_s;

  // Rotate requests so ptr lands on bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    rot_s = '0;
    src_s = '0;
    off_s = '0;
    for (int i = 0; i < ARB_N; i++) begin
      src_s    = i[ARB_IDX_W-1:0] + ptr;
      rot_s[i] = req[src_s];
    end
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = i[ARB_IDX_W-1:0];
      end else begin
        off_s = off_s;
      end
    end
    found = |req;
    idx   = off_s + ptr;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with hold limit and one dead cycle between owners.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic           clk,
  input logic           reset_n,
  rr_arbiter8_if.slave  bus
);

  localparam bit HOLD_EN     = (MAX_HOLD != 0);
  localparam int HOLD_W      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_LAST_I[HOLD_W-1:0];

  arb_state_t           state_q, state_d;
  logic [ARB_N-1:0]     gnt_q, gnt_d;
  logic [ARB_IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;

  logic                 pick_found_s;
  logic [ARB_IDX_W-1:0] pick_idx_s;
  logic                 owner_req_s;
  logic                 others_s;
  logic                 forced_s;

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;

  // Next-state and output-register logic; a new grant always restarts the hold counter.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    owner_req_s = |(bus.req & gnt_q);
    others_s    = |(bus.req & ~gnt_q);
    forced_s    = HOLD_EN && (hold_q == HOLD_LAST) && others_s;

    case (state_q)
      IDLE, HANDOFF: begin
        if (pick_found_s) begin
          state_d     = GRANT;
          gnt_d       = idx_to_onehot(pick_idx_s);
          gnt_idx_d   = pick_idx_s;
          gnt_valid_d = 1'b1;
          hold_d      = '0;
        end else begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!owner_req_s || forced_s) begin
          // Release: the select stays on the old owner through the dead cycle.
          state_d     = HANDOFF;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 3'd1;
        end else if (HOLD_EN && (hold_q != HOLD_LAST)) begin
          hold_d = hold_q + HOLD_W'(1'b1);
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the grant immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized self-checking bench for rr_arbiter8 against a behavioural ownership model.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       reset_n;
  logic [7:0] req_s;
  logic [7:0] data_s;
  logic       mux_out_s;

  int tests_run;
  int tests_failed;

  // Reference model: who owns the line, for how many cycles, where the search starts.
  int m_owner;
  int m_ptr;
  int m_held;
  int m_last;

  rr_arbiter8_if bus ();
  assign bus.req   = req_s;
  assign mux_out_s = data_s[bus.gnt_idx];

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_search(input logic [7:0] r, input int p);
    for (int i = 0; i < 8; i++) begin
      if (r[(p + i) % 8]) return (p + i) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_last  = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    logic [7:0] others;
    int w;
    if (m_owner >= 0) begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner] || (MAX_HOLD != 0 && m_held >= MAX_HOLD && others != 8'd0)) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else begin
      w = m_search(r, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
        m_last  = w;
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] exp_gnt;
    int gi;
    exp_gnt = 8'd0;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    check_eq("gnt", 32'(bus.gnt), 32'(exp_gnt));
    check_eq("gnt_idx", 32'(bus.gnt_idx), 32'(m_last[2:0]));
    check_eq("gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
    check_eq("inv_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    check_eq("inv_valid", 32'(bus.gnt_valid), 32'(|bus.gnt));
    if (bus.gnt_valid) begin
      gi = 0;
      for (int i = 0; i < 8; i++) if (bus.gnt[i]) gi = i;
      check_eq("inv_idx", 32'(bus.gnt_idx), 32'(gi));
      check_eq("mux_bit", 32'(mux_out_s), 32'(data_s[m_last]));
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step(req_s);
    @(negedge clk);
    compare_all();
    data_s = 8'($urandom);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req_s   = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
    check_eq("rst_idx", 32'(bus.gnt_idx), 32'd0);
    check_eq("rst_valid", 32'(bus.gnt_valid), 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    int order_q[$];
    int run_idx_q[$];
    int run_len_q[$];
    int run_len;
    int cnt;
    logic prev_valid;

    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    req_s        = 8'd0;
    data_s       = 8'hA5;
    model_reset();

    // Test 1: idle after reset.
    apply_reset();
    repeat (5) step_cycle();

    // Test 2: two requesters, owner drops.
    req_s = 8'b0010_0100;
    step_cycle();
    check_eq("t2_first_gnt", 32'(bus.gnt), 32'h04);
    check_eq("t2_first_idx", 32'(bus.gnt_idx), 32'd2);
    req_s = 8'b0010_0000;
    step_cycle();
    check_eq("t2_dead_gnt", 32'(bus.gnt), 32'h00);
    check_eq("t2_dead_idx", 32'(bus.gnt_idx), 32'd2);
    step_cycle();
    check_eq("t2_next_gnt", 32'(bus.gnt), 32'h20);
    check_eq("t2_next_idx", 32'(bus.gnt_idx), 32'd5);
    req_s = 8'd0;
    repeat (3) step_cycle();

    // Test 3: everyone requests, each owner drops 3 cycles into its grant.
    apply_reset();
    req_s      = 8'hFF;
    prev_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step_cycle();
      if (bus.gnt_valid && !prev_valid) order_q.push_back(int'(bus.gnt_idx));
      prev_valid = bus.gnt_valid;
      if (m_owner >= 0 && m_held == 3) req_s[m_owner] = 1'b0;
      else req_s = 8'hFF;
    end
    check_eq("t3_grants", 32'(order_q.size() >= 9), 32'd1);
    for (int i = 0; i < 9 && i < order_q.size(); i++) check_eq("t3_order", 32'(order_q[i]), 32'(i % 8));

    // Test 4: two persistent requesters alternate on the hold limit.
    apply_reset();
    req_s   = 8'h48;
    run_len = 0;
    for (int c = 0; c < 70; c++) begin
      step_cycle();
      if (bus.gnt_valid) begin
        if (run_len == 0) run_idx_q.push_back(int'(bus.gnt_idx));
        run_len++;
      end else if (run_len != 0) begin
        run_len_q.push_back(run_len);
        run_len = 0;
      end
    end
    check_eq("t4_runs", 32'(run_len_q.size() >= 3), 32'd1);
    for (int i = 0; i < 3 && i < run_len_q.size(); i++) begin
      check_eq("t4_len", 32'(run_len_q[i]), 32'(MAX_HOLD));
      check_eq("t4_owner", 32'(run_idx_q[i]), (i % 2 == 0) ? 32'd3 : 32'd6);
    end

    // Test 5: lone requester is never forced off; a second one takes over at the limit.
    apply_reset();
    req_s = 8'h80;
    cnt   = 0;
    for (int c = 0; c < 100; c++) begin
      step_cycle();
      if (bus.gnt == 8'h80) cnt++;
    end
    check_eq("t5_hold", 32'(cnt), 32'd100);
    req_s = 8'h81;
    step_cycle();
    check_eq("t5_forced", 32'(bus.gnt), 32'h00);
    step_cycle();
    check_eq("t5_switch", 32'(bus.gnt), 32'h01);
    req_s = 8'd0;
    repeat (2) step_cycle();

    // Test 6: asynchronous reset in the middle of a grant.
    apply_reset();
    req_s = 8'h10;
    repeat (3) step_cycle();
    check_eq("t6_owner", 32'(bus.gnt), 32'h10);
    #1 reset_n = 1'b0;
    #2;
    check_eq("t6_async_gnt", 32'(bus.gnt), 32'h00);
    check_eq("t6_async_valid", 32'(bus.gnt_valid), 32'd0);
    check_eq("t6_async_idx", 32'(bus.gnt_idx), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    req_s   = 8'h30;
    step_cycle();
    check_eq("t6_after_gnt", 32'(bus.gnt), 32'h10);

    // Random traffic: owners hold longer, other requesters toggle freely.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if (b == m_owner) begin
          if ($urandom_range(0, 39) == 0) req_s[b] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          req_s[b] = ~req_s[b];
        end
      end
      if ($urandom_range(0, 199) == 0) req_s = 8'd0;
      step_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
